// File: rtl/ariane_ace.sv
// ACE snoop channel types shared by the snoop path (AC request, CR response, CD data).
package ariane_ace;

  typedef struct packed {
    logic [63:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ace_ac_chan_t;

  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } ace_cd_chan_t;

  typedef struct packed {
    logic         ac_valid;
    ace_ac_chan_t ac;
    logic         cr_ready;
    logic         cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic         ac_ready;
    logic         cr_valid;
    crresp_t      cr_resp;
    logic         cd_valid;
    ace_cd_chan_t cd;
  } snoop_resp_t;

endpackage

// File: rtl/std_cache_pkg.sv
// Cache-wide constants used by the snoop channel buffer.
package std_cache_pkg;

  // 128-bit cache line carried over a 64-bit CD channel.
  localparam int unsigned DefaultCdBeats = 2;
  localparam int unsigned BeatCntW       = 3;

endpackage

// File: rtl/snoop_resp_slice.sv
// One-entry valid/ready register slice; drains and reloads in the same cycle.
module snoop_resp_slice #(
  parameter type payload_t = logic
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     in_valid_i,
  output logic     in_ready_o,
  input  payload_t in_data_i,
  output logic     out_valid_o,
  input  logic     out_ready_i,
  output payload_t out_data_o
);

  logic     full_q;
  payload_t data_q;
  logic     load;

  assign in_ready_o  = !full_q || out_ready_i;
  assign load        = in_valid_i && in_ready_o;
  assign out_valid_o = full_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (load) begin
        full_q <= 1'b1;
        data_q <= in_data_i;
      end else if (out_ready_i) begin
        full_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/snoop_chan_buffer.sv
// Buffers ACE snoop traffic between the interconnect and the snoop cache controller,
// allowing one snoop in flight and flagging downstream CR/CD protocol violations.
module snoop_chan_buffer
  import ariane_ace::*;
  import std_cache_pkg::*;
#(
  parameter int unsigned AcDepth = 2,
  parameter int unsigned CdBeats = DefaultCdBeats
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  snoop_req_t  up_req_i,
  output snoop_resp_t up_resp_o,
  output snoop_req_t  dn_req_o,
  input  snoop_resp_t dn_resp_i,
  input  logic        hold_i,
  output logic        busy_o,
  output logic        proto_err_o
);

  localparam int unsigned PtrW = (AcDepth > 1) ? $clog2(AcDepth) : 1;
  localparam int unsigned CntW = $clog2(AcDepth + 1);
  localparam int unsigned SumW = BeatCntW + 1;

  ace_ac_chan_t          fifo_mem [AcDepth];
  logic [PtrW-1:0]       rd_ptr, wr_ptr;
  logic [CntW-1:0]       count;
  logic                  outstanding;
  logic [BeatCntW-1:0]   beats_pending, beats_next;
  logic [SumW-1:0]       beats_sum;

  logic fifo_full, fifo_empty, push, pop, dn_ac_valid;
  logic dn_cr_ready, dn_cd_ready, cr_hs, cd_hs;
  logic up_cr_valid, up_cd_valid;
  crresp_t      up_cr_resp;
  ace_cd_chan_t up_cd;

  assign fifo_full   = (count == CntW'(AcDepth));
  assign fifo_empty  = (count == '0);
  assign push        = up_req_i.ac_valid && !fifo_full;
  // Only one snoop downstream at a time, and never while its data is still arriving.
  assign dn_ac_valid = !fifo_empty && !hold_i && !outstanding && (beats_pending == '0);
  assign pop         = dn_ac_valid && dn_resp_i.ac_ready;
  assign cr_hs       = dn_resp_i.cr_valid && dn_cr_ready;
  assign cd_hs       = dn_resp_i.cd_valid && dn_cd_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < AcDepth; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= up_req_i.ac;
        wr_ptr <= (wr_ptr == PtrW'(AcDepth - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PtrW'(AcDepth - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Net beat accounting; floors at zero on stray beats and caps at the counter maximum.
  always_comb begin
    beats_sum = {1'b0, beats_pending};
    if (cr_hs && dn_resp_i.cr_resp.data_transfer) beats_sum = beats_sum + SumW'(CdBeats);
    if (cd_hs) beats_sum = (beats_sum == '0) ? '0 : beats_sum - 1'b1;
    beats_next = beats_sum[SumW-1] ? '1 : beats_sum[BeatCntW-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding   <= 1'b0;
      beats_pending <= '0;
    end else begin
      if (pop) outstanding <= 1'b1;
      else if (cr_hs) outstanding <= 1'b0;
      beats_pending <= beats_next;
    end
  end

  snoop_resp_slice #(.payload_t(crresp_t)) i_cr_slice (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (dn_resp_i.cr_valid),
    .in_ready_o  (dn_cr_ready),
    .in_data_i   (dn_resp_i.cr_resp),
    .out_valid_o (up_cr_valid),
    .out_ready_i (up_req_i.cr_ready),
    .out_data_o  (up_cr_resp)
  );

  snoop_resp_slice #(.payload_t(ace_cd_chan_t)) i_cd_slice (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (dn_resp_i.cd_valid),
    .in_ready_o  (dn_cd_ready),
    .in_data_i   (dn_resp_i.cd),
    .out_valid_o (up_cd_valid),
    .out_ready_i (up_req_i.cd_ready),
    .out_data_o  (up_cd)
  );

  always_comb begin
    dn_req_o          = '0;
    dn_req_o.ac_valid = dn_ac_valid;
    dn_req_o.ac       = fifo_mem[rd_ptr];
    dn_req_o.cr_ready = dn_cr_ready;
    dn_req_o.cd_ready = dn_cd_ready;

    up_resp_o          = '0;
    up_resp_o.ac_ready = !fifo_full;
    up_resp_o.cr_valid = up_cr_valid;
    up_resp_o.cr_resp  = up_cr_resp;
    up_resp_o.cd_valid = up_cd_valid;
    up_resp_o.cd       = up_cd;
  end

  assign busy_o = !fifo_empty || outstanding || up_cr_valid || up_cd_valid
                  || (beats_pending != '0);

  assign proto_err_o = (cd_hs && ((beats_pending == '0)
                                  || (dn_resp_i.cd.last != (beats_pending == BeatCntW'(1)))))
                       || (cr_hs && !outstanding);

endmodule

// File: tb/tb_snoop_chan_buffer.sv
// Random-stimulus bench for snoop_chan_buffer, checked every cycle against a queue-based model.
module tb_snoop_chan_buffer;
  import ariane_ace::*;

  localparam int AcDepth = 2;
  localparam int CdBeats = 2;
  localparam int BeatMax = 7;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        hold_i = 1'b0;
  snoop_req_t  up_req_i, dn_req_o;
  snoop_resp_t up_resp_o, dn_resp_i;
  logic        busy_o, proto_err_o;

  always #5 clk_i = ~clk_i;

  snoop_chan_buffer #(.AcDepth(AcDepth), .CdBeats(CdBeats)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .up_req_i    (up_req_i),
    .up_resp_o   (up_resp_o),
    .dn_req_o    (dn_req_o),
    .dn_resp_i   (dn_resp_i),
    .hold_i      (hold_i),
    .busy_o      (busy_o),
    .proto_err_o (proto_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: snoops waiting, one-snoop-in-flight flag, beats owed, held responses.
  ace_ac_chan_t m_fifo[$];
  crresp_t      m_cr[$];
  ace_cd_chan_t m_cd[$];
  bit           m_outst;
  int           m_beats;

  logic e_ac_ready, e_dn_valid, e_cr_ready, e_cd_ready, e_busy, e_err, cr_hs, cd_hs;
  bit   draining = 1'b0;

  function automatic void reset_model();
    m_fifo.delete();
    m_cr.delete();
    m_cd.delete();
    m_outst = 1'b0;
    m_beats = 0;
  endfunction

  task automatic idle_inputs();
    up_req_i  = '0;
    dn_resp_i = '0;
    hold_i    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ac_ready"}, 128'(up_resp_o.ac_ready), 128'(1));
    check_eq({tag, "_cr_valid"}, 128'(up_resp_o.cr_valid), 128'(0));
    check_eq({tag, "_cd_valid"}, 128'(up_resp_o.cd_valid), 128'(0));
    check_eq({tag, "_dn_ac_valid"}, 128'(dn_req_o.ac_valid), 128'(0));
    check_eq({tag, "_dn_cr_ready"}, 128'(dn_req_o.cr_ready), 128'(1));
    check_eq({tag, "_dn_cd_ready"}, 128'(dn_req_o.cd_ready), 128'(1));
    check_eq({tag, "_busy"}, 128'(busy_o), 128'(0));
    check_eq({tag, "_proto_err"}, 128'(proto_err_o), 128'(0));
  endtask

  task automatic drive_random();
    bit inject;
    inject = !draining && ($urandom_range(0, 29) == 0);
    up_req_i.ac_valid   = !draining && ($urandom_range(0, 2) != 0);
    up_req_i.ac.addr    = {$urandom, $urandom};
    up_req_i.ac.snoop   = 4'($urandom);
    up_req_i.ac.prot    = 3'($urandom);
    up_req_i.cr_ready   = draining || ($urandom_range(0, 3) != 0);
    up_req_i.cd_ready   = draining || ($urandom_range(0, 3) != 0);
    hold_i              = !draining && ($urandom_range(0, 6) == 0);
    dn_resp_i.ac_ready  = ($urandom_range(0, 2) != 0);
    dn_resp_i.cr_valid  = (m_outst && ($urandom_range(0, 1) == 1)) || (inject && ($urandom_range(0, 1) == 1));
    dn_resp_i.cr_resp   = crresp_t'(5'($urandom));
    dn_resp_i.cd_valid  = ((m_beats > 0) && ($urandom_range(0, 1) == 1)) || (inject && ($urandom_range(0, 1) == 1));
    dn_resp_i.cd.data   = {$urandom, $urandom};
    dn_resp_i.cd.last   = inject ? ($urandom_range(0, 1) == 1) : (m_beats == 1);
  endtask

  task automatic compare_cycle();
    e_ac_ready = (m_fifo.size() < AcDepth);
    e_dn_valid = (m_fifo.size() > 0) && !hold_i && !m_outst && (m_beats == 0);
    e_cr_ready = (m_cr.size() == 0) || up_req_i.cr_ready;
    e_cd_ready = (m_cd.size() == 0) || up_req_i.cd_ready;
    cr_hs      = dn_resp_i.cr_valid && e_cr_ready;
    cd_hs      = dn_resp_i.cd_valid && e_cd_ready;
    e_err      = (cd_hs && ((m_beats == 0) || (dn_resp_i.cd.last != (m_beats == 1))))
                 || (cr_hs && !m_outst);
    e_busy     = (m_fifo.size() > 0) || m_outst || (m_cr.size() > 0) || (m_cd.size() > 0)
                 || (m_beats != 0);

    check_eq("up_ac_ready", 128'(up_resp_o.ac_ready), 128'(e_ac_ready));
    check_eq("dn_ac_valid", 128'(dn_req_o.ac_valid), 128'(e_dn_valid));
    if (e_dn_valid) check_eq("dn_ac_payload", 128'(dn_req_o.ac), 128'(m_fifo[0]));
    check_eq("dn_cr_ready", 128'(dn_req_o.cr_ready), 128'(e_cr_ready));
    check_eq("dn_cd_ready", 128'(dn_req_o.cd_ready), 128'(e_cd_ready));
    check_eq("up_cr_valid", 128'(up_resp_o.cr_valid), 128'(m_cr.size() > 0));
    if (m_cr.size() > 0) check_eq("up_cr_resp", 128'(up_resp_o.cr_resp), 128'(m_cr[0]));
    check_eq("up_cd_valid", 128'(up_resp_o.cd_valid), 128'(m_cd.size() > 0));
    if (m_cd.size() > 0) check_eq("up_cd_beat", 128'(up_resp_o.cd), 128'(m_cd[0]));
    check_eq("busy", 128'(busy_o), 128'(e_busy));
    check_eq("proto_err", 128'(proto_err_o), 128'(e_err));
  endtask

  task automatic update_model();
    int nb;
    bit popped;
    popped = e_dn_valid && dn_resp_i.ac_ready;
    if (popped) void'(m_fifo.pop_front());
    if (up_req_i.ac_valid && e_ac_ready) m_fifo.push_back(up_req_i.ac);
    nb = m_beats + ((cr_hs && dn_resp_i.cr_resp.data_transfer) ? CdBeats : 0) - (cd_hs ? 1 : 0);
    m_beats = (nb < 0) ? 0 : ((nb > BeatMax) ? BeatMax : nb);
    if (popped) m_outst = 1'b1;
    else if (cr_hs) m_outst = 1'b0;
    if ((m_cr.size() > 0) && up_req_i.cr_ready) void'(m_cr.pop_front());
    if (cr_hs) m_cr.push_back(dn_resp_i.cr_resp);
    if ((m_cd.size() > 0) && up_req_i.cd_ready) void'(m_cd.pop_front());
    if (cd_hs) m_cd.push_back(dn_resp_i.cd);
  endtask

  initial begin
    idle_inputs();
    reset_model();
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk_i);
      if (cyc > 100 && $urandom_range(0, 399) == 0) begin
        idle_inputs();
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        reset_model();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        continue;
      end
      draining = (cyc >= 3800);
      drive_random();
      #1;
      compare_cycle();
      @(posedge clk_i);
      update_model();
    end

    @(negedge clk_i);
    idle_inputs();
    up_req_i.cr_ready = 1'b1;
    up_req_i.cd_ready = 1'b1;
    #1;
    check_eq("drain_busy", 128'(busy_o), 128'(0));
    check_eq("drain_dn_ac_valid", 128'(dn_req_o.ac_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snoop_chan_buffer.md
SNOOP_CHAN_BUFFER -- requirements
Module: snoop_chan_buffer

Interface
REQ-001 Parameter AcDepth, default 2, gives the number of AC FIFO entries; legal values are 1..8.
REQ-002 Parameter CdBeats, default 2, gives the CD beats per cache line (128-bit line over a 64-bit CD).
REQ-003 The module SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- up_req_i  in  ariane_ace::snoop_req_t  interconnect side: ac_valid, ac, cr_ready, cd_ready.
- up_resp_o  out  ariane_ace::snoop_resp_t  interconnect side: ac_ready, cr_valid, cr_resp, cd_valid, cd.
- dn_req_o  out  ariane_ace::snoop_req_t  to the snoop cache controller.
- dn_resp_i  in  ariane_ace::snoop_resp_t  from the snoop cache controller.
- hold_i  in  1  blocks AC dispatch downstream; used during flush.
- busy_o  out  1  a transaction is in flight anywhere in the block.
- proto_err_o  out  1  one-cycle pulse on a downstream protocol violation.

Function
REQ-004 AC FIFO: up_resp_o.ac_ready = !full; a push occurs on up ac_valid && ac_ready and stores the whole ac struct.
REQ-005 There is no fall-through: a pushed entry SHALL first be visible on dn_req_o.ac_valid in the cycle after the push.
REQ-006 Dispatch: dn_req_o.ac_valid = !empty && !hold_i && (outstanding == 0), and dn_req_o.ac = FIFO head.
REQ-007 A pop occurs on dn ac_valid && dn_resp_i.ac_ready.
- Push and pop in the same cycle SHALL leave the count unchanged.
- Push when full SHALL NOT occur.
- The read and write pointers wrap modulo AcDepth.
REQ-008 outstanding is a 1-bit flag:
- set on pop;
- cleared on a downstream CR handshake (dn cr_valid && dn_req_o.cr_ready);
- if both events occur in one cycle, it SHALL be set.
REQ-009 CR slice: a 1-entry register.
- dn_req_o.cr_ready = !cr_full || up_req_i.cr_ready.
- up_resp_o.cr_valid = cr_full, and cr_resp is taken from the register.
- Simultaneous drain and load SHALL sustain one response per cycle.
REQ-010 CD slice: identical structure to the CR slice, applied to cd_valid, cd, and cd_ready.
REQ-011 beats_pending counter, 3 bits:
- +CdBeats on a downstream CR handshake with dataTransfer = 1;
- -1 on each downstream CD handshake;
- both in one cycle SHALL apply the net value.
REQ-012 proto_err_o SHALL pulse in the cycle of the offending handshake, in any of these cases:
- a downstream CD handshake while beats_pending == 0;
- cd.last = 1 while beats_pending != 1;
- cd.last = 0 while beats_pending == 1;
- a downstream CR handshake while outstanding == 0.
REQ-013 On a protocol error, beats_pending SHALL saturate at 0 and data SHALL still be forwarded; there is no blocking.
REQ-014 dn_req_o.ac_valid SHALL additionally be held low while beats_pending != 0, so CD data of consecutive snoops never interleaves.
REQ-015 busy_o = !empty || outstanding || cr_full || cd_full || (beats_pending != 0).
REQ-016 hold_i asserted mid-transaction affects only new dispatch; CR and CD forwarding for the outstanding snoop SHALL continue.
REQ-017 All fields of the snoop_req_t and snoop_resp_t structs not mentioned above SHALL be driven to 0.

Reset
REQ-018 On reset, the following SHALL be cleared: FIFO pointers and count, outstanding, cr_full, cd_full, beats_pending; stored payloads are reset to 0.
REQ-019 Reset values of outputs:
- up_resp_o.ac_ready = 1; cr_valid = cd_valid = 0;
- dn_req_o.ac_valid = 0; cr_ready = cd_ready = 1;
- busy_o = 0; proto_err_o = 0.
REQ-020 Reset asserted mid-transfer SHALL drop all in-flight state with no partial responses emitted after release.

Structure
REQ-021 CdBeats default and any beat-counter width constants SHALL live in std_cache_pkg; no new typedefs are required beyond ariane_ace types.
REQ-022 The CR and CD slices SHALL be two instances of one sub-module, snoop_resp_slice, parameterised by payload type.
REQ-023 The AC FIFO is implemented inline.

Verification
REQ-024 Single ReadShared:
- Stimulus: push an AC at cycle 0 with downstream ac_ready = 1.
- Response: dn ac_valid at cycle 1; dn returns CR{dataTransfer=1} then 2 CD beats (last on beat 2); upstream sees CR and then both beats in order; busy_o = 0 one cycle after the final upstream CD handshake.
REQ-025 Back-to-back AC, AcDepth = 2:
- Stimulus: 3 pushes in consecutive cycles with downstream stalled (ac_ready = 0).
- Response: up ac_ready = 0 after 2 pushes; the third push is accepted only after the first pop.
REQ-026 Ordering:
- Stimulus: second AC queued while beats_pending = 2.
- Response: dn ac_valid stays 0 until both CD beats have handshaked downstream and outstanding = 0.
REQ-027 Upstream backpressure:
- Stimulus: up cr_ready = 0 for 5 cycles.
- Response: dn cr_ready = 0 once the CR slice is full; no CR is lost or duplicated; release delivers exactly 1 CR.
REQ-028 Protocol error:
- Stimulus: dn drives a CD beat with no prior dataTransfer CR.
- Response: proto_err_o = 1 for exactly 1 cycle; beats_pending stays 0.
REQ-029 Reset mid-op:
- Stimulus: assert rst_ni low with FIFO count = 2 and beats_pending = 1.
- Response: all outputs at reset values; after release, no stale AC, CR or CD appears.
